restoring_div_controller: RTL and testbench

- FSM that sequences the 10-by-5-bit restoring divider datapath: operand load, then 5 × (subtract, test/restore, shift).
- Sits beside the datapath in the divider top level. Drives its load, select, shift, serial-in and add/sub controls. Observes only the datapath's `sign` output.
- Exposes a ready/start/done handshake to the surrounding logic.

---
 rtl/div_pkg.sv | 17 +
 rtl/div_iter_counter.sv | 27 ++
 rtl/restoring_div_controller.sv | 108 ++++++++++
 tb/tb_restoring_div_controller.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the restoring divider controller.
package div_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SUB   = 3'd2,
    CHK   = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } div_state_t;

  localparam int   DIV_QBITS  = 5;
  localparam logic ADDSUB_SUB = 1'b1;
  localparam logic ADDSUB_ADD = 1'b0;

endpackage

// File: rtl/div_iter_counter.sv
// Iteration counter: cleared on operand load, bumped per shift, flags the last iteration.
module div_iter_counter #(
  parameter int QBITS = 5,
  parameter int CW    = (QBITS > 1) ? $clog2(QBITS) : 1
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_tc
);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tc = (r_count == CW'(QBITS - 1));

endmodule

// File: rtl/restoring_div_controller.sv
// Sequencer for the 10-by-5 restoring divider: load, then QBITS x (subtract, test/restore, shift).
module restoring_div_controller
  import div_pkg::*;
#(
  parameter int   QBITS   = DIV_QBITS,
  parameter logic SUB_POL = ADDSUB_SUB
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic sign,
  output logic ready,
  output logic done,
  output logic diviendLd,
  output logic divisorLd,
  output logic dividendSel,
  output logic shl,
  output logic sin,
  output logic addSubSelect
);

  div_state_t r_state;
  div_state_t w_state_next;
  logic       r_qbit;
  logic       w_tc;
  logic       w_cnt_clr;
  logic       w_cnt_inc;

  assign w_cnt_clr = (r_state == LOAD);
  assign w_cnt_inc = (r_state == SHIFT) && !w_tc;

  div_iter_counter #(
    .QBITS (QBITS)
  ) u_iter_counter (
    .clk     (clk),
    .i_rst_n (rst),
    .i_clr   (w_cnt_clr),
    .i_inc   (w_cnt_inc),
    .o_tc    (w_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Quotient bit is the complement of the post-subtract sign, captured only in CHK.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_qbit <= 1'b0;
    end else if (r_state == CHK) begin
      r_qbit <= ~sign;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = LOAD;
      LOAD:    w_state_next = SUB;
      SUB:     w_state_next = CHK;
      CHK:     w_state_next = SHIFT;
      SHIFT:   w_state_next = w_tc ? DONE : SUB;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    ready        = 1'b0;
    done         = 1'b0;
    diviendLd    = 1'b0;
    divisorLd    = 1'b0;
    dividendSel  = 1'b0;
    shl          = 1'b0;
    sin          = 1'b0;
    addSubSelect = ~SUB_POL;
    case (r_state)
      IDLE: ready = 1'b1;
      LOAD: begin
        diviendLd = 1'b1;
        divisorLd = 1'b1;
      end
      SUB: begin
        diviendLd    = 1'b1;
        dividendSel  = 1'b1;
        addSubSelect = SUB_POL;
      end
      CHK: begin
        // Negative partial remainder: add the divisor back.
        if (sign) begin
          diviendLd   = 1'b1;
          dividendSel = 1'b1;
        end
      end
      SHIFT: begin
        shl = 1'b1;
        sin = r_qbit;
      end
      DONE:    done = 1'b1;
      default: ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_restoring_div_controller.sv
// Controller bench with a behavioural datapath; Q/R and sequencing checked against plain arithmetic.
module tb_restoring_div_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic sign;
  logic ready, done, diviendLd, divisorLd, dividendSel, shl, sin, addSubSelect;

  logic [9:0] ext_a = '0;
  logic [4:0] ext_b = '0;
  logic [9:0] dp_dividend = '0;
  logic [4:0] dp_divisor = '0;
  logic [5:0] addsub_res;

  int total = 0;
  int bad = 0;
  int last_q, last_r;

  always #5 clk = ~clk;

  restoring_div_controller dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .sign         (sign),
    .ready        (ready),
    .done         (done),
    .diviendLd    (diviendLd),
    .divisorLd    (divisorLd),
    .dividendSel  (dividendSel),
    .shl          (shl),
    .sin          (sin),
    .addSubSelect (addSubSelect)
  );

  // Datapath stand-in: 10-bit dividend/remainder register, 5-bit divisor, 6-bit add/sub on [9:4].
  assign addsub_res = addSubSelect ? (dp_dividend[9:4] - {1'b0, dp_divisor})
                                   : (dp_dividend[9:4] + {1'b0, dp_divisor});
  assign sign = dp_dividend[9];

  always @(posedge clk) begin
    if (diviendLd)
      dp_dividend <= dividendSel ? {addsub_res, dp_dividend[3:0]} : ext_a;
    else if (shl)
      dp_dividend <= {dp_dividend[8:0], sin};
    if (divisorLd)
      dp_divisor <= ext_b;
  end

  // Starts a division in the current cycle (cycle 0) and follows it to cycle 17.
  task automatic run_div(input logic [9:0] a, input logic [4:0] b, input int restart_cyc,
                         input bit hold, input string tag);
    int exp_q, exp_r, k, ph, restores, shl_cnt, exp_restores;
    logic [4:0] eq;
    exp_q = int'(a) / int'(b);
    exp_r = int'(a) % int'(b);
    eq = exp_q[4:0];
    exp_restores = 5 - $countones(eq);
    restores = 0;
    shl_cnt = 0;
    @(negedge clk);
    ext_a = a;
    ext_b = b;
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL %s ready_idle got=%b exp=1", tag, ready);
    end
    start = 1'b1;
    for (int cyc = 1; cyc <= 17; cyc++) begin
      @(negedge clk);
      if (!hold) start = (cyc == restart_cyc);
      total++;
      if (ready !== 1'b0) begin
        bad++;
        $display("FAIL %s ready_busy cyc=%0d got=%b exp=0", tag, cyc, ready);
      end
      total++;
      if (done !== (cyc == 17)) begin
        bad++;
        $display("FAIL %s done cyc=%0d got=%b exp=%b", tag, cyc, done, (cyc == 17));
      end
      if (cyc == 1) begin
        total++;
        if (divisorLd !== 1'b1 || diviendLd !== 1'b1 || dividendSel !== 1'b0) begin
          bad++;
          $display("FAIL %s load cyc=1 got=%b%b%b exp=110", tag, divisorLd, diviendLd, dividendSel);
        end
      end
      if (shl === 1'b1) shl_cnt++;
      if (cyc >= 2 && cyc <= 16) begin
        k = (cyc - 2) / 3;
        ph = (cyc - 2) % 3;
        if (ph == 0) begin
          total++;
          if (addSubSelect !== 1'b1 || diviendLd !== 1'b1) begin
            bad++;
            $display("FAIL %s sub k=%0d got=%b%b exp=11", tag, k, addSubSelect, diviendLd);
          end
        end
        if (ph == 1 && diviendLd === 1'b1) restores++;
        if (ph == 2) begin
          total++;
          if (shl !== 1'b1 || sin !== eq[4-k]) begin
            bad++;
            $display("FAIL %s sin k=%0d got=shl%b/sin%b exp=shl1/sin%b", tag, k, shl, sin, eq[4-k]);
          end
        end
      end
    end
    total++;
    if (int'(dp_dividend[4:0]) !== exp_q) begin
      bad++;
      $display("FAIL %s quotient %0d/%0d got=%0d exp=%0d", tag, a, b, dp_dividend[4:0], exp_q);
    end
    total++;
    if (int'(dp_dividend[9:5]) !== exp_r) begin
      bad++;
      $display("FAIL %s remainder %0d/%0d got=%0d exp=%0d", tag, a, b, dp_dividend[9:5], exp_r);
    end
    total++;
    if (restores !== exp_restores) begin
      bad++;
      $display("FAIL %s restores got=%0d exp=%0d", tag, restores, exp_restores);
    end
    total++;
    if (shl_cnt !== 5) begin
      bad++;
      $display("FAIL %s shl_count got=%0d exp=5", tag, shl_cnt);
    end
    last_q = int'(dp_dividend[4:0]);
    last_r = int'(dp_dividend[9:5]);
    $display("txn %s: %0d/%0d -> Q=%0d R=%0d (ref Q=%0d R=%0d)", tag, a, b, last_q, last_r, exp_q, exp_r);
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({ready, done, diviendLd, divisorLd, dividendSel, shl, sin, addSubSelect} !== 8'b1000_0000) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=10000000",
               {ready, done, diviendLd, divisorLd, dividendSel, shl, sin, addSubSelect});
    end
    @(negedge clk);
    rst = 1'b1;
    $display("txn reset released");
  endtask

  task automatic test_directed();
    run_div(10'd100, 5'd7, 0, 1'b0, "100/7");
    run_div(10'd991, 5'd31, 0, 1'b0, "991/31");
    run_div(10'd0, 5'd5, 0, 1'b0, "0/5");
  endtask

  task automatic test_ignore_start();
    run_div(10'd155, 5'd31, 8, 1'b0, "155/31_restart8");
    @(negedge clk);
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL ignore_start ready_c18 got=%b exp=1", ready);
    end
    @(negedge clk);
    total++;
    if (ready !== 1'b1 || divisorLd !== 1'b0) begin
      bad++;
      $display("FAIL ignore_start c19 got=ready%b/ld%b exp=ready1/ld0", ready, divisorLd);
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    ext_a = 10'd100;
    ext_b = 5'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 2; cyc <= 10; cyc++) @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({ready, done, diviendLd, divisorLd, dividendSel, shl, sin, addSubSelect} !== 8'b1000_0000) begin
      bad++;
      $display("FAIL mid_reset outputs got=%b exp=10000000",
               {ready, done, diviendLd, divisorLd, dividendSel, shl, sin, addSubSelect});
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0 || ready !== 1'b1) begin
        bad++;
        $display("FAIL mid_reset idle i=%0d got=done%b/ready%b exp=done0/ready1", i, done, ready);
      end
    end
    $display("txn mid-operation reset handled");
    run_div(10'd100, 5'd7, 0, 1'b0, "100/7_after_reset");
  endtask

  task automatic test_back_to_back();
    int q1, r1;
    run_div(10'd100, 5'd7, 0, 1'b1, "b2b_first");
    q1 = last_q;
    r1 = last_r;
    run_div(10'd100, 5'd7, 0, 1'b1, "b2b_second");
    start = 1'b0;
    total++;
    if (last_q !== q1 || last_r !== r1) begin
      bad++;
      $display("FAIL back_to_back got=%0d/%0d exp=%0d/%0d", last_q, last_r, q1, r1);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [4:0] b, hi, lo;
    for (int n = 0; n < 12; n++) begin
      b = 5'($urandom_range(31, 1));
      hi = 5'($urandom_range(int'(b) - 1, 0));
      lo = 5'($urandom_range(31, 0));
      run_div({hi, lo}, b, 0, 1'b0, $sformatf("rand%0d", n));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
